edge_event_unit: RTL

EDGE_EVENT_UNIT -- requirements
Module: edge_event_unit

---
 rtl/edge_pkg.sv | 26 ++
 rtl/edge_channel.sv | 78 +++++++
 rtl/edge_event_unit.sv | 70 +++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge event unit.
package edge_pkg;

  // Per-channel edge selection, two bits per channel on mode_i.
  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } edge_mode_t;

  // True when the detected edge is one the channel's mode cares about.
  function automatic logic edge_enabled(input edge_mode_t mode,
                                        input logic       rise,
                                        input logic       fall);
    logic en;
    case (mode)
      MODE_RISE: en = rise;
      MODE_FALL: en = fall;
      MODE_BOTH: en = rise | fall;
      default:   en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchroniser chain, debounce filter and registered
// rise/fall pulse generation. The *_evt_o outputs are the next-cycle values
// of the pulses so the parent can update its flags on the same edge.
module edge_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  output logic rise_o,
  output logic fall_o,
  output logic rise_evt_o,
  output logic fall_evt_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter value at which one more differing cycle completes the filter.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic                   stable_prev_q, stable_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Next-state: shift the synchroniser, run the debounce filter, detect edges.
  always_comb begin
    // NOTE: every _d gets a default before any branch, so no path can leave
    // a signal unassigned and infer a latch.
    sync_d        = {sync_q[SYNC_STAGES-2:0], a_i};
    stable_d      = stable_q;
    cnt_d         = '0;
    stable_prev_d = stable_q;
    rise_d        = stable_q & ~stable_prev_q;
    fall_d        = ~stable_q & stable_prev_q;
    if (sync != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge
    // values regardless of statement order.
    if (!rst) begin
      sync_q        <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      cnt_q         <= '0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      cnt_q         <= cnt_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
    end
  end

  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign rise_evt_o = rise_d;
  assign fall_evt_o = fall_d;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: per-channel filtered edge detection plus
// sticky pending/overflow flags and a registered interrupt request.
module edge_event_unit
  import edge_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS-1:0]   a_i,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   clear_i,
  output logic [CHANNELS-1:0]   rise_o,
  output logic [CHANNELS-1:0]   fall_o,
  output logic [CHANNELS-1:0]   pending_o,
  output logic [CHANNELS-1:0]   overflow_o,
  output logic                  irq_o
);

  logic [CHANNELS-1:0] rise_evt, fall_evt, edge_en;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] overflow_q, overflow_d;
  logic                irq_q, irq_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .a_i       (a_i[g]),
      .rise_o    (rise_o[g]),
      .fall_o    (fall_o[g]),
      .rise_evt_o(rise_evt[g]),
      .fall_evt_o(fall_evt[g])
    );

    // Mode is sampled on the same edge the pulse registers.
    assign edge_en[g] = edge_enabled(edge_mode_t'(mode_i[2*g +: 2]),
                                     rise_evt[g], fall_evt[g]);
  end

  // Sticky flags: a new enabled edge beats a coincident clear.
  always_comb begin
    pending_d  = edge_en | (pending_q & ~clear_i);
    overflow_d = ~clear_i & (overflow_q | (edge_en & pending_q));
    irq_d      = |pending_q;
  end

  // Flag and interrupt registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q  <= '0;
      overflow_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;
  assign irq_o      = irq_q;

endmodule
